// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for the operand-forwarding scoreboard: decode request,
// register-file and stage result buses in, forwarded operands and stall out.
interface fwd_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3,
    parameter int LAT_W  = 2
);
    logic                     id_valid;
    logic                     id_wr_en;
    logic [REG_AW-1:0]        id_rd;
    logic [LAT_W-1:0]         id_lat;
    logic [NSRC*REG_AW-1:0]   id_src;
    logic [NSRC*DATA_W-1:0]   rf_data;
    logic [DEPTH*DATA_W-1:0]  stage_data;
    logic                     ex_kill;
    logic [NSRC*DATA_W-1:0]   opnd;
    logic [NSRC*2-1:0]        fwd_sel;
    logic                     stall;
    logic [15:0]              stall_cnt;

    modport master (
        output id_valid, id_wr_en, id_rd, id_lat, id_src, rf_data, stage_data, ex_kill,
        input  opnd, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_wr_en, id_rd, id_lat, id_src, rf_data, stage_data, ex_kill,
        output opnd, fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight register writes; selects the youngest
// ready producer per decode operand and stalls decode on an unready one.
module fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3,
    parameter int LAT_W  = 2
) (
    input logic             clk,
    input logic             rst_n,
    fwd_scoreboard_if.slave sb
);

    logic [DEPTH-1:0]        ent_vld_q, ent_vld_d;
    logic [REG_AW-1:0]       ent_rd_q  [DEPTH];
    logic [REG_AW-1:0]       ent_rd_d  [DEPTH];
    logic [LAT_W-1:0]        ent_lat_q [DEPTH];
    logic [LAT_W-1:0]        ent_lat_d [DEPTH];
    logic [15:0]             stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]         hit;
    logic [NSRC-1:0]         blocked;
    logic [NSRC*DATA_W-1:0]  opnd_c;
    logic [NSRC*2-1:0]       sel_c;
    logic                    stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // Decode: scan stages youngest-first so an older ready producer can never
    // bypass a younger one that is still computing.
    always_comb begin
        hit     = '0;
        blocked = '0;
        opnd_c  = sb.rf_data;
        sel_c   = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit[s] && ent_vld_q[k] &&
                    ent_rd_q[k] == sb.id_src[s*REG_AW +: REG_AW] &&
                    sb.id_src[s*REG_AW +: REG_AW] != '0) begin
                    hit[s] = 1'b1;
                    if (k >= int'(ent_lat_q[k])) begin
                        sel_c[s*2 +: 2]           = 2'(k + 1);
                        opnd_c[s*DATA_W +: DATA_W] = sb.stage_data[k*DATA_W +: DATA_W];
                    end else begin
                        blocked[s] = 1'b1;
                    end
                end
            end
        end
        stall = sb.id_valid & (|blocked);
    end

    // Decode -> stage 0 and stage k -> k+1; a kill invalidates what leaves stage 0.
    always_comb begin
        ent_vld_d    = '0;
        ent_vld_d[0] = sb.id_valid & sb.id_wr_en & ~stall & (sb.id_rd != '0);
        ent_rd_d[0]  = sb.id_rd;
        ent_lat_d[0] = (sb.id_lat == '0) ? LAT_W'(1) : sb.id_lat;
        for (int k = 1; k < DEPTH; k++) begin
            ent_vld_d[k] = ent_vld_q[k-1];
            ent_rd_d[k]  = ent_rd_q[k-1];
            ent_lat_d[k] = ent_lat_q[k-1];
        end
        ent_vld_d[1] = ent_vld_q[0] & ~sb.ex_kill;
        stall_cnt_d  = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_vld_q   <= ent_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_rd_q  <= ent_rd_d;
        ent_lat_q <= ent_lat_d;
    end

    assign sb.opnd      = opnd_c;
    assign sb.fwd_sel   = sel_c;
    assign sb.stall     = stall;
    assign sb.stall_cnt = stall_cnt_q;

endmodule
